// File: rtl/fifo_pkg.sv
// Shared definitions for the write side of the 80-bit dual-clock FIFO:
// word geometry, header field offsets and the word assembly helper.
package fifo_pkg;

    localparam int LANE_W   = 16;
    localparam int LANES    = 4;
    localparam int HDR_W    = 16;
    localparam int DSIZE    = LANES * LANE_W + HDR_W;
    localparam int MASK_LSB = 64;
    localparam int LAST_BIT = 68;
    localparam int SEQ_LSB  = 69;
    localparam int SEQ_W    = 11;

    // Field order is MSB first, so the packed layout lands on the header
    // offsets above: seq at [79:69], last at [68], mask at [67:64].
    typedef struct packed {
        logic [SEQ_W-1:0]        seq;
        logic                    last;
        logic [LANES-1:0]        mask;
        logic [LANES*LANE_W-1:0] lanes;
    } fifo_word_t;

    // Assemble one FIFO word; lane 0 sits in the lowest LANE_W bits.
    function automatic fifo_word_t build_word(
        input logic [LANES*LANE_W-1:0] lanes,
        input logic [LANES-1:0]        mask,
        input logic                    last,
        input logic [SEQ_W-1:0]        seq
    );
        fifo_word_t w;
        w.lanes = lanes;
        w.mask  = mask;
        w.last  = last;
        w.seq   = seq;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_idle_timer.sv
// Idle timer for the write packer: counts cycles with an open partial word
// and pulses fire once the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module fifo_wr_idle_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic wclk,
    input  logic wrst_n,
    input  logic clear,
    input  logic run,
    output logic fire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{wclk, wrst_n, clear, run};
            assign fire          = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] idle_cnt_reg;

            // Restart on every accept; count while running; hold at the limit so
            // a word that cannot move yet does not trigger a second close.
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) begin
                    idle_cnt_reg <= '0;
                end else if (clear) begin
                    idle_cnt_reg <= '0;
                end else if (run && (idle_cnt_reg != LIMIT)) begin
                    idle_cnt_reg <= idle_cnt_reg + CW'(1);
                end
            end

            assign fire = run & (idle_cnt_reg == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_packer.sv
// Write-side ingress stage of the 80-bit dual-clock FIFO. Packs 16-bit
// samples into 4-lane words with a mask/last/sequence header and drives the
// FIFO write port, respecting the registered wfull flag.
module fifo_wr_packer #(
    parameter int LANE_W  = 16,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic                       s_valid,
    input  logic [LANE_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    input  logic                       flush_req,
    output logic [fifo_pkg::DSIZE-1:0] wdata,
    output logic                       winc,
    input  logic                       wfull,
    output logic [15:0]                words_sent
);

    import fifo_pkg::*;

    localparam int ACC_W = $clog2(LANES + 1);

    // Accumulator: lane storage, fill count, "closed but not yet moved" flag
    logic [LANE_W-1:0]       lane_reg [LANES];
    logic [LANES*LANE_W-1:0] lanes_flat;
    logic [LANES-1:0]        mask_cur;
    logic [LANES-1:0]        lane_we;
    logic [ACC_W-1:0]        acc_cnt_reg;
    logic [ACC_W-1:0]        acc_cnt_next;
    logic [ACC_W-1:0]        base_cnt;
    logic [ACC_W-1:0]        cnt_inc;
    logic                    closed_reg;
    logic                    closed_next;
    logic                    acc_last_reg;
    logic                    acc_last_next;

    // Output register and counters
    fifo_word_t              out_reg;
    fifo_word_t              out_next;
    logic                    out_valid_reg;
    logic                    out_valid_next;
    logic [SEQ_W-1:0]        seq_reg;
    logic [SEQ_W-1:0]        seq_stamp;
    logic [15:0]             words_sent_reg;
    logic                    ready_en_reg;

    // Control terms
    logic                    accept;
    logic                    out_free;
    logic                    acc_nonempty;
    logic                    close_now;
    logic                    move_now;
    logic                    timer_run;
    logic                    timer_fire;

    assign winc         = out_valid_reg & ~wfull;
    assign out_free     = ~out_valid_reg | winc;
    // A closed word blocks input only when it cannot move this cycle.
    // Written against out_free (not move_now) so s_ready never depends on accept.
    assign s_ready      = ready_en_reg & (~closed_reg | out_free);
    assign accept       = s_valid & s_ready;
    assign acc_nonempty = (acc_cnt_reg != '0);
    // Flush or timeout on an open, non-empty word with no sample arriving.
    // With an accept, a flush is folded into the accept path instead.
    assign close_now    = ~closed_reg & acc_nonempty & ~accept & (flush_req | timer_fire);
    assign move_now     = (closed_reg | close_now) & out_free;
    assign base_cnt     = move_now ? '0 : acc_cnt_reg;
    assign cnt_inc      = base_cnt + ACC_W'(1);
    assign timer_run    = acc_nonempty & ~closed_reg;
    // A word loaded while the previous one drains takes the next number.
    assign seq_stamp    = seq_reg + SEQ_W'(winc);

    assign wdata        = out_reg;
    assign words_sent   = words_sent_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
            assign lane_we[gi]                       = accept & (base_cnt == ACC_W'(gi));
            assign mask_cur[gi]                      = (acc_cnt_reg > ACC_W'(gi));
            assign lanes_flat[gi*LANE_W +: LANE_W]   = lane_reg[gi];

            // Per-lane storage: take the sample aimed at this lane, otherwise
            // clear when the word leaves so unused lanes read back as zero.
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) begin
                    lane_reg[gi] <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg[gi] <= s_data;
                end else if (move_now) begin
                    lane_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    fifo_wr_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .clear  (accept),
        .run    (timer_run),
        .fire   (timer_fire)
    );

    // Accumulator bookkeeping: empty on move, then apply this cycle's accept
    // or a flush/timeout close that has to wait for the output register.
    always_comb begin
        acc_cnt_next  = acc_cnt_reg;
        closed_next   = closed_reg;
        acc_last_next = acc_last_reg;
        if (move_now) begin
            acc_cnt_next  = '0;
            closed_next   = 1'b0;
            acc_last_next = 1'b0;
        end
        if (accept) begin
            acc_cnt_next = cnt_inc;
            if ((cnt_inc == ACC_W'(LANES)) || s_last || flush_req) begin
                closed_next   = 1'b1;
                acc_last_next = s_last;
            end
        end else if (close_now && !move_now) begin
            closed_next   = 1'b1;
            acc_last_next = 1'b0;
        end
    end

    // Output register: load a closed word when free, otherwise drop the
    // valid flag once the FIFO has taken the current word.
    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        if (move_now) begin
            out_next       = build_word(lanes_flat, mask_cur, acc_last_reg, seq_stamp);
            out_valid_next = 1'b1;
        end else if (winc) begin
            out_valid_next = 1'b0;
        end
    end

    // State registers for accumulator control and output stage.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            acc_cnt_reg   <= '0;
            closed_reg    <= 1'b0;
            acc_last_reg  <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            acc_cnt_reg   <= acc_cnt_next;
            closed_reg    <= closed_next;
            acc_last_reg  <= acc_last_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            ready_en_reg  <= 1'b1;
        end
    end

    // Sequence number and write counter advance on every FIFO write; both wrap.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            seq_reg        <= '0;
            words_sent_reg <= '0;
        end else if (winc) begin
            seq_reg        <= seq_reg + SEQ_W'(1);
            words_sent_reg <= words_sent_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: a stimulus/expected-word table for the
// basic packing cases plus hand sequences for flush, timeout, back-pressure,
// mid-word reset and sequence wrap.
module tb_fifo_wr_packer;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        flush_req;
    logic [79:0] wdata;
    logic        winc;
    logic        wfull;
    logic [15:0] words_sent;

    always #5 wclk = ~wclk;

    fifo_wr_packer #(
        .LANE_W  (16),
        .LANES   (4),
        .TIMEOUT (64)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .flush_req  (flush_req),
        .wdata      (wdata),
        .winc       (winc),
        .wfull      (wfull),
        .words_sent (words_sent)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int proto_viol = 0;
    int acc_cnt_tb = 0;
    int last_acc_cyc = 0;
    bit done3 = 1'b0;

    typedef struct {
        logic [79:0] data;
        int          cyc;
    } cap_t;
    cap_t cap_q[$];

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        flush;
    } stim_t;

    typedef struct {
        string       name;
        logic [79:0] word;
    } exp_t;

    stim_t stim[14];
    exp_t  expv[4];

    always @(posedge wclk) cyc <= cyc + 1;

    // One line per FIFO write; also flag any write attempted while full.
    always @(negedge wclk) begin
        if (winc && wfull) proto_viol++;
        if (winc) begin
            cap_q.push_back('{wdata, cyc});
            $display("tx %0d: seq=%0d last=%0b mask=%h lanes=%h cyc=%0d",
                     cap_q.size() - 1, wdata[79:69], wdata[68], wdata[67:64], wdata[63:0], cyc);
        end
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3,
                                       input logic [3:0] mask, input logic last,
                                       input logic [10:0] seq);
        return {seq, last, mask, l3, l2, l1, l0};
    endfunction

    function automatic logic [79:0] cap_word(input int i);
        if (i < cap_q.size()) return cap_q[i].data;
        return 'x;
    endfunction

    function automatic int cap_cyc(input int i);
        if (i < cap_q.size()) return cap_q[i].cyc;
        return -1;
    endfunction

    // Called at a negedge; presents a sample until accepted, returns at the
    // negedge after the accepting edge with inputs idle.
    task automatic send(input logic [15:0] d, input logic last, input logic flush);
        int n;
        n = 0;
        s_valid   = 1'b1;
        s_data    = d;
        s_last    = last;
        flush_req = flush;
        while (!s_ready && n < 200) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready low for sample %h, required high", d);
        end else begin
            @(posedge wclk);
            @(negedge wclk);
            acc_cnt_tb++;
            last_acc_cyc = cyc;
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge wclk);
            k++;
        end
        if (cap_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_words: got %0d words, required %0d", cap_q.size(), n);
        end
    endtask

    initial begin
        int first_cyc;
        int hold_base;
        int unstable;
        int n;
        logic [79:0] ref_word;

        wrst_n    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        flush_req = 1'b0;
        wfull     = 1'b0;

        // Samples 1..8, then A,B,C(last), then 11,12,13 with flush on the third
        for (int i = 0; i < 8; i++) stim[i] = '{16'(i + 1), 1'b0, 1'b0};
        stim[8]  = '{16'h000A, 1'b0, 1'b0};
        stim[9]  = '{16'h000B, 1'b0, 1'b0};
        stim[10] = '{16'h000C, 1'b1, 1'b0};
        stim[11] = '{16'h0011, 1'b0, 1'b0};
        stim[12] = '{16'h0012, 1'b0, 1'b0};
        stim[13] = '{16'h0013, 1'b0, 1'b1};
        expv[0] = '{"t1_word0", mk(16'h1, 16'h2, 16'h3, 16'h4, 4'hF, 1'b0, 11'd0)};
        expv[1] = '{"t1_word1", mk(16'h5, 16'h6, 16'h7, 16'h8, 4'hF, 1'b0, 11'd1)};
        expv[2] = '{"t2_last_word", mk(16'hA, 16'hB, 16'hC, 16'h0, 4'h7, 1'b1, 11'd2)};
        expv[3] = '{"t5_flush_word", mk(16'h11, 16'h12, 16'h13, 16'h0, 4'h7, 1'b0, 11'd3)};

        // Reset state
        repeat (2) @(negedge wclk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_words_sent", words_sent, 0);
        wrst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", s_ready, 0);
        @(negedge wclk);
        chk("ready_after_first_edge", s_ready, 1);

        // Table-driven packing: full words, s_last word, flush-with-accept word
        first_cyc = 0;
        for (int i = 0; i < 14; i++) begin
            send(stim[i].data, stim[i].last, stim[i].flush);
            if (i == 0) first_cyc = last_acc_cyc;
            if (i == 7) chk("t1_one_sample_per_cycle", last_acc_cyc - first_cyc, 7);
        end
        wait_words(4, 50);
        chk("table_word_count", cap_q.size(), 4);
        for (int i = 0; i < 4; i++) chk(expv[i].name, cap_word(i), expv[i].word);
        chk("table_words_sent", words_sent, 4);

        // Flush with an empty accumulator does nothing
        flush_req = 1'b1;
        @(negedge wclk);
        flush_req = 1'b0;
        repeat (10) @(negedge wclk);
        chk("t5_flush_empty_no_winc", cap_q.size(), 4);

        // Idle timeout closes a 2-sample word 64 cycles after the last accept
        send(16'h0021, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 1'b0);
        n = last_acc_cyc;
        wait_words(5, 120);
        chk("t4_timeout_delay", cap_cyc(4) - n, 64);
        chk("t4_timeout_word", cap_word(4), mk(16'h21, 16'h22, 16'h0, 16'h0, 4'h3, 1'b0, 11'd4));

        // Back-pressure: wfull held 20 cycles while 12 samples stream in
        @(posedge wclk);
        #1 wfull = 1'b1;
        @(negedge wclk);
        acc_cnt_tb = 0;
        hold_base  = cap_q.size();
        unstable   = 0;
        ref_word   = '0;
        fork
            begin
                for (int k = 0; k < 12; k++) send(16'h0100 + 16'(k), 1'b0, 1'b0);
                done3 = 1'b1;
            end
        join_none
        for (int h = 1; h <= 20; h++) begin
            @(negedge wclk);
            if (h == 6) ref_word = wdata;
            if (h > 6 && wdata !== ref_word) unstable++;
        end
        chk("t3_accepts_while_full", acc_cnt_tb, 8);
        chk("t3_ready_low_while_full", s_ready, 0);
        chk("t3_no_winc_while_full", cap_q.size(), hold_base);
        chk("t3_wdata_stable", unstable, 0);
        chk("t3_held_word", wdata, mk(16'h100, 16'h101, 16'h102, 16'h103, 4'hF, 1'b0, 11'd5));
        @(posedge wclk);
        #1 wfull = 1'b0;
        n = 0;
        while (!done3 && n < 300) begin
            @(negedge wclk);
            n++;
        end
        chk("t3_stream_done", done3, 1);
        wait_words(hold_base + 3, 50);
        chk("t3_word_a", cap_word(hold_base),     mk(16'h100, 16'h101, 16'h102, 16'h103, 4'hF, 1'b0, 11'd5));
        chk("t3_word_b", cap_word(hold_base + 1), mk(16'h104, 16'h105, 16'h106, 16'h107, 4'hF, 1'b0, 11'd6));
        chk("t3_word_c", cap_word(hold_base + 2), mk(16'h108, 16'h109, 16'h10A, 16'h10B, 4'hF, 1'b0, 11'd7));
        chk("t3_words_sent", words_sent, 8);

        // Reset with a word in the output register and a partial in the accumulator
        for (int k = 0; k < 4; k++) send(16'h0031 + 16'(k), 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 16'h0035;
        @(posedge wclk);
        #1;
        chk("t6_winc_before_reset", winc, 1);
        wrst_n  = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("t6_winc_in_reset", winc, 0);
        chk("t6_words_sent_in_reset", words_sent, 0);
        chk("t6_wdata_in_reset", wdata, 0);
        chk("t6_ready_in_reset", s_ready, 0);
        cap_q.delete();
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge wclk);

        // First word after reset has seq 0; then 2048 more words to wrap seq
        for (int k = 0; k < 4; k++) send(16'h0051 + 16'(k), 1'b0, 1'b0);
        for (int w = 1; w <= 2048; w++) begin
            for (int j = 0; j < 4; j++) send(16'(w * 4 + j), 1'b0, 1'b0);
        end
        wait_words(2049, 100);
        chk("t6_no_stale_word", cap_q.size(), 2049);
        chk("t6_first_word_after_reset", cap_word(0), mk(16'h51, 16'h52, 16'h53, 16'h54, 4'hF, 1'b0, 11'd0));
        chk("wrap_seq_2047", cap_word(2047), mk(16'h1FFC, 16'h1FFD, 16'h1FFE, 16'h1FFF, 4'hF, 1'b0, 11'd2047));
        chk("wrap_seq_0", cap_word(2048), mk(16'h2000, 16'h2001, 16'h2002, 16'h2003, 4'hF, 1'b0, 11'd0));
        chk("wrap_words_sent", words_sent, 2049);

        chk("winc_while_full_count", proto_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
